// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and size derivation for the scoreboarded register file.
package reg_file_sb_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 2;

  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Write, read and reserve bus of the register file; master drives requests, slave returns data/status.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd0_addr;
  logic        [ADDR_W-1:0] rd1_addr;
  logic                     rsv_en;
  logic        [ADDR_W-1:0] rsv_addr;
  logic signed [DATA_W-1:0] rd0_data;
  logic signed [DATA_W-1:0] rd1_data;
  logic                     rd_valid;
  logic                     stall;
  logic                     rsv_err;
  logic          [ADDR_W:0] busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd0_addr, rd1_addr, rsv_en, rsv_addr,
    input  rd0_data, rd1_data, rd_valid, stall, rsv_err, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd0_addr, rd1_addr, rsv_en, rsv_addr,
    output rd0_data, rd1_data, rd_valid, stall, rsv_err, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: tracks pending destinations, blocks reads of them, flags double reserves.
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic              stall_o,
  output logic              rsv_err_o,
  output logic   [ADDR_W:0] busy_cnt_o
);
  localparam int DEPTH = depth_f(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_err_q, rsv_err_d;
  logic  [ADDR_W:0] busy_cnt_q, busy_cnt_d;
  logic             blk0, blk1;

  function automatic logic [ADDR_W:0] popcnt(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  // A same-cycle write releases its register, so it never blocks a read of it.
  assign blk0    = busy_q[rd0_addr_i] && !(wr_en_i && (wr_addr_i == rd0_addr_i));
  assign blk1    = busy_q[rd1_addr_i] && !(wr_en_i && (wr_addr_i == rd1_addr_i));
  assign stall_o = rd_en_i && (blk0 || blk1);

  always_comb begin
    busy_d = busy_q;
    if (wr_en_i)  busy_d[wr_addr_i]  = 1'b0;
    if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
    rsv_err_d  = rsv_en_i && busy_q[rsv_addr_i] && !(wr_en_i && (wr_addr_i == rsv_addr_i));
    busy_cnt_d = popcnt(busy_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rsv_err_q  <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rsv_err_q  <= rsv_err_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rsv_err_o  = rsv_err_q;
  assign busy_cnt_o = busy_cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-through forwarding and a busy scoreboard that stalls reads of pending registers.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave rf
);
  localparam int DEPTH = depth_f(ADDR_W);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] rd0_data_q, rd1_data_q, rd0_data_d, rd1_data_d;
  logic                     rd_valid_q;
  logic                     wr_eff, rsv_eff, stall, rd_acc;

  // With ZERO_REG, address 0 is invisible to writes and reserves alike.
  assign wr_eff  = rf.wr_en  && !(ZERO_REG && (rf.wr_addr  == '0));
  assign rsv_eff = rf.rsv_en && !(ZERO_REG && (rf.rsv_addr == '0));
  assign rd_acc  = rf.rd_en && !stall;

  function automatic logic signed [DATA_W-1:0] src_val(
    input logic        [ADDR_W-1:0] addr,
    input logic signed [DATA_W-1:0] stored,
    input logic                     we,
    input logic        [ADDR_W-1:0] waddr,
    input logic signed [DATA_W-1:0] wdata
  );
    if (ZERO_REG && (addr == '0)) return '0;
    if (we && (waddr == addr))    return wdata;
    return stored;
  endfunction

  always_comb begin
    rd0_data_d = src_val(rf.rd0_addr, mem_q[rf.rd0_addr], wr_eff, rf.wr_addr, rf.wr_data);
    rd1_data_d = src_val(rf.rd1_addr, mem_q[rf.rd1_addr], wr_eff, rf.wr_addr, rf.wr_data);
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_eff),
    .wr_addr_i  (rf.wr_addr),
    .rsv_en_i   (rsv_eff),
    .rsv_addr_i (rf.rsv_addr),
    .rd_en_i    (rf.rd_en),
    .rd0_addr_i (rf.rd0_addr),
    .rd1_addr_i (rf.rd1_addr),
    .stall_o    (stall),
    .rsv_err_o  (rf.rsv_err),
    .busy_cnt_o (rf.busy_cnt)
  );

  // Storage and read-port registers: read data is presented one cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_eff) mem_q[rf.wr_addr] <= rf.wr_data;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd0_data_q <= rd0_data_d;
        rd1_data_q <= rd1_data_d;
      end
    end
  end

  assign rf.stall    = stall;
  assign rf.rd0_data = rd0_data_q;
  assign rf.rd1_data = rd1_data_q;
  assign rf.rd_valid = rd_valid_q;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 9: register and data-port width in bits; legal range 1-64.
REQ-002 Parameter ADDR_W, default 2: address width; DEPTH = 2**ADDR_W registers; legal range 1-6.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 is hardwired to zero.
REQ-004 clk  input  1  clock; all state changes on rising edge except reset.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  signed write data.
REQ-009 rd_en  input  1  read request for both read ports.
REQ-010 rd0_addr, rd1_addr  input  ADDR_W each  read addresses.
REQ-011 rsv_en  input  1  reserve strobe; marks a destination register as pending.
REQ-012 rsv_addr  input  ADDR_W  register to reserve.
REQ-013 rd0_data, rd1_data  output  DATA_W each  registered signed read data.
REQ-014 rd_valid  output  1  registered; high for one cycle when rd0_data/rd1_data were updated by an accepted read.
REQ-015 stall  output  1  combinational; read request refused this cycle.
REQ-016 rsv_err  output  1  registered; one-cycle pulse when a reserve targets an already-busy register.
REQ-017 busy_cnt  output  ADDR_W+1  registered count of busy registers.

Function
REQ-018 Storage: DEPTH x DATA_W registers plus one busy bit per register.
REQ-019 Write: on rising edge with wr_en=1, registers[wr_addr] <= wr_data, and busy[wr_addr] <= 0 unless REQ-023 applies.
REQ-020 stall = rd_en AND (source 0 blocked OR source 1 blocked).
REQ-021 Source n is blocked when busy[rdn_addr]=1, unless wr_en=1 and wr_addr=rdn_addr in the same cycle.
REQ-022 Read:
- Accepted when rd_en=1 and stall=0; latency 1 cycle.
- Next edge: rdn_data <= value of registers[rdn_addr]; rd_valid <= 1.
- If wr_en=1 and wr_addr=rdn_addr in the same cycle, rdn_data <= wr_data (write-through forwarding; new value, never old).
- Otherwise rd_valid <= 0 and rd0_data/rd1_data hold their values.
REQ-023 Reserve: on rising edge with rsv_en=1, busy[rsv_addr] <= 1.
- Reserve and write to the same address in one cycle: data is written and busy ends at 1 (reserve wins).
REQ-024 rsv_err <= 1 for one cycle when rsv_en=1, busy[rsv_addr]=1 and the register is not being cleared by a same-cycle write; the busy bit stays 1.
REQ-025 busy_cnt equals the population count of the busy bits after each edge; never exceeds DEPTH.
REQ-026 ZERO_REG=1:
- Writes to address 0 are discarded.
- Reserves of address 0 are ignored and never raise rsv_err.
- Reads of address 0 return 0 and are never blocked, including when a same-cycle write targets address 0.
REQ-027 A write to a non-busy register is legal and clears nothing else.
REQ-028 rd0_addr = rd1_addr is legal; both ports return the same value.

Reset
REQ-029 While rst=1:
- All registers are 0, all busy bits are 0.
- rd0_data = rd1_data = 0; rd_valid = rsv_err = 0; busy_cnt = 0.
REQ-030 Reset asserted mid-operation discards pending reserves and any in-flight read; the first edge after deassertion is a normal cycle.

Structure
REQ-031 Shared package holds the DATA_W/ADDR_W defaults and a DEPTH derivation function; no typedefs are needed.
REQ-032 One sub-module, rf_scoreboard, owns the busy bits, rsv_err and busy_cnt; the top module owns storage, forwarding and read registers.

Verification
REQ-033 Reset, then write 5 to r1 and -3 to r2, then read r1/r2 -> next cycle rd0_data=5, rd1_data=-3 (0x1FD), rd_valid=1.
REQ-034 Reserve r3, then read r3 -> stall=1 and rd_valid=0; write 7 to r3 while the read is held -> stall=0 that cycle, next cycle rd0_data=7, busy_cnt returns to 0.
REQ-035 Write 9 to r2 and read r2 in the same cycle -> rd0_data=9 (forwarded).
REQ-036 Reserve r1 twice -> second reserve gives rsv_err pulse, busy_cnt=1; same-cycle write+reserve on r2 -> busy_cnt=2, no rsv_err.
REQ-037 ZERO_REG=1: write 4 to r0, reserve r0, read r0 -> rd0_data=0, stall=0, busy_cnt=0.
REQ-038 Assert rst with 2 busy registers and a read pending -> all outputs 0, busy_cnt=0 immediately, before the next clock edge.
